// File: rtl/tetris_game_ctrl.sv
// Game control FSM for the Tetris datapath: piece lifecycle, gravity timing,
// soft drop, pause, line clearing and level/lines bookkeeping.
module tetris_game_ctrl #(
    parameter int ROWS            = 20,
    parameter int GEN_CYCLES      = 2,
    parameter int BASE_PERIOD     = 48,
    parameter int PERIOD_STEP     = 4,
    parameter int MIN_PERIOD      = 4,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             pause,
    input  logic                             frame_tick,
    input  logic                             key_rot,
    input  logic                             key_left,
    input  logic                             key_right,
    input  logic                             key_drop,
    input  logic                             landed,
    input  logic                             spawn_blocked,
    input  logic                             row_full,
    output logic                             drawing_board,
    output logic                             gen_shape,
    output logic                             new_lines,
    output logic                             set_shape,
    output logic                             fall_step,
    output logic                             rotate,
    output logic                             move_left,
    output logic                             move_right,
    output logic                             lock_piece,
    output logic                             clear_row,
    output logic [$clog2(ROWS)-1:0]          row_addr,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
    output logic [15:0]                      lines_total,
    output logic                             paused,
    output logic                             game_over
);

    localparam int ROW_W   = $clog2(ROWS);
    localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);
    localparam int GRAV_W  = $clog2(BASE_PERIOD + 1);
    localparam int CLR_W   = $clog2(ROWS + 1);
    localparam int LPL_W   = $clog2(LINES_PER_LEVEL + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SPAWN, S_GEN, S_PLACE, S_FALL, S_PAUSED, S_LOCK, S_CLEAR, S_LOST
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           gen_cnt_q, gen_cnt_d;
    logic [GRAV_W-1:0]    grav_cnt_q, grav_cnt_d;
    logic [ROW_W-1:0]     row_addr_q, row_addr_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [15:0]          lines_q, lines_d;
    logic [LPL_W-1:0]     line_cnt_q, line_cnt_d;
    logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;

    logic [31:0]          drop_amt;
    logic [31:0]          period;
    logic                 step_due;

    // Gravity period with a floor; soft drop forces a step on every tick.
    always_comb begin
        drop_amt = 32'(level_q) * 32'(PERIOD_STEP);
        if (key_drop)
            period = 32'd1;
        else if (drop_amt + 32'(MIN_PERIOD) >= 32'(BASE_PERIOD))
            period = 32'(MIN_PERIOD);
        else
            period = 32'(BASE_PERIOD) - drop_amt;
        step_due = frame_tick && (32'(grav_cnt_q) >= period - 32'd1);
    end

    always_comb begin
        state_d    = state_q;
        gen_cnt_d  = gen_cnt_q;
        grav_cnt_d = grav_cnt_q;
        row_addr_d = row_addr_q;
        level_d    = level_q;
        lines_d    = lines_q;
        line_cnt_d = line_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        gen_shape  = 1'b0;
        new_lines  = 1'b0;
        set_shape  = 1'b0;
        fall_step  = 1'b0;
        rotate     = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        lock_piece = 1'b0;
        clear_row  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SPAWN;
                    level_d    = '0;
                    lines_d    = '0;
                    line_cnt_d = '0;
                end
            end
            S_SPAWN: begin
                gen_shape = 1'b1;
                gen_cnt_d = '0;
                state_d   = S_GEN;
            end
            S_GEN: begin
                new_lines = 1'b1;
                if (gen_cnt_q == 4'(GEN_CYCLES - 1))
                    state_d = S_PLACE;
                else
                    gen_cnt_d = gen_cnt_q + 4'd1;
            end
            S_PLACE: begin
                set_shape  = 1'b1;
                grav_cnt_d = '0;
                state_d    = spawn_blocked ? S_LOST : S_FALL;
            end
            S_FALL: begin
                // Pause outranks a due step; the held counter defers it.
                if (pause) begin
                    state_d = S_PAUSED;
                end else if (step_due) begin
                    grav_cnt_d = '0;
                    if (landed)
                        state_d = S_LOCK;
                    else
                        fall_step = 1'b1;
                end else begin
                    if (frame_tick)
                        grav_cnt_d = grav_cnt_q + GRAV_W'(1);
                    rotate     = key_rot;
                    move_left  = key_left & ~key_right;
                    move_right = key_right & ~key_left;
                end
            end
            S_PAUSED: begin
                if (pause)
                    state_d = S_FALL;
            end
            S_LOCK: begin
                lock_piece = 1'b1;
                row_addr_d = ROW_W'(ROWS - 1);
                clr_cnt_d  = '0;
                state_d    = S_CLEAR;
            end
            S_CLEAR: begin
                if (row_full) begin
                    clear_row = 1'b1;
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    if (lines_q != 16'hFFFF)
                        lines_d = lines_q + 16'd1;
                    if (line_cnt_q == LPL_W'(LINES_PER_LEVEL - 1)) begin
                        line_cnt_d = '0;
                        if (level_q != LEVEL_W'(MAX_LEVEL))
                            level_d = level_q + LEVEL_W'(1);
                    end else begin
                        line_cnt_d = line_cnt_q + LPL_W'(1);
                    end
                    // A board that keeps reporting full rows cannot trap us here.
                    if (clr_cnt_q == CLR_W'(ROWS - 1))
                        state_d = S_SPAWN;
                end else if (row_addr_q != '0) begin
                    row_addr_d = row_addr_q - ROW_W'(1);
                end else begin
                    state_d = S_SPAWN;
                end
            end
            S_LOST: begin
                if (start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (reset) begin
            gen_shape  = 1'b0;
            new_lines  = 1'b0;
            set_shape  = 1'b0;
            fall_step  = 1'b0;
            rotate     = 1'b0;
            move_left  = 1'b0;
            move_right = 1'b0;
            lock_piece = 1'b0;
            clear_row  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gen_cnt_q  <= '0;
            grav_cnt_q <= '0;
            row_addr_q <= ROW_W'(ROWS - 1);
            level_q    <= '0;
            lines_q    <= '0;
            line_cnt_q <= '0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gen_cnt_q  <= gen_cnt_d;
            grav_cnt_q <= grav_cnt_d;
            row_addr_q <= row_addr_d;
            level_q    <= level_d;
            lines_q    <= lines_d;
            line_cnt_q <= line_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    assign drawing_board = (state_q == S_IDLE);
    assign paused        = (state_q == S_PAUSED);
    assign game_over     = (state_q == S_LOST);
    assign row_addr      = row_addr_q;
    assign level         = level_q;
    assign lines_total   = lines_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Scenario bench for tetris_game_ctrl: expected events are queued when stimulus
// is driven and compared against what the controller actually produces.
module tb_tetris_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, pause = 1'b0, frame_tick = 1'b0;
    logic        key_rot = 1'b0, key_left = 1'b0, key_right = 1'b0, key_drop = 1'b0;
    logic        landed = 1'b0, spawn_blocked = 1'b0;
    logic        row_full;
    logic        drawing_board, gen_shape, new_lines, set_shape, fall_step;
    logic        rotate, move_left, move_right, lock_piece, clear_row;
    logic [4:0]  row_addr;
    logic [3:0]  level;
    logic [15:0] lines_total;
    logic        paused, game_over;

    logic [19:0] board = '0;
    logic        force_full = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          lines_model = 0;
    int          exp_q[$];
    int          seen_q[$];
    logic [3:0]  exp_vec_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign row_full = force_full | board[row_addr];

    // Datapath stand-in: a cleared row becomes empty.
    always @(posedge clk)
        if (!reset && clear_row) board[row_addr] <= 1'b0;

    tetris_game_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .frame_tick(frame_tick),
        .key_rot(key_rot), .key_left(key_left), .key_right(key_right), .key_drop(key_drop),
        .landed(landed), .spawn_blocked(spawn_blocked), .row_full(row_full),
        .drawing_board(drawing_board), .gen_shape(gen_shape), .new_lines(new_lines),
        .set_shape(set_shape), .fall_step(fall_step), .rotate(rotate),
        .move_left(move_left), .move_right(move_right), .lock_piece(lock_piece),
        .clear_row(clear_row), .row_addr(row_addr), .level(level),
        .lines_total(lines_total), .paused(paused), .game_over(game_over)
    );

    function automatic int period_of(input int lvl);
        int p;
        p = 48 - lvl * 4;
        return (p < 4) ? 4 : p;
    endfunction

    function automatic int level_of(input int lines);
        return (lines / 10 > 15) ? 15 : lines / 10;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_set_shape(output bit to);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (set_shape) begin
                to = 1'b0;
                step();
                break;
            end
            step();
        end
    endtask

    // From the first CLEAR slot: record cleared row addresses until gen_shape.
    task automatic collect_clears(output bit to, output int gs_cyc);
        to = 1'b1;
        gs_cyc = 0;
        seen_q.delete();
        for (int i = 0; i < 80; i++) begin
            #1;
            if (gen_shape) begin
                to = 1'b0;
                gs_cyc = cyc;
                step();
                break;
            end
            if (clear_row) seen_q.push_back(int'(row_addr));
            step();
        end
    endtask

    task automatic do_lock(output bit to, output int n_clr);
        int gs;
        key_drop = 1'b1; landed = 1'b1; frame_tick = 1'b1;
        step();
        key_drop = 1'b0; landed = 1'b0; frame_tick = 1'b0;
        step();
        collect_clears(to, gs);
        n_clr = seen_q.size();
    endtask

    task automatic observe_falls(input int n);
        seen_q.delete();
        for (int i = 0; i < n; i++) begin
            #1;
            if (fall_step) seen_q.push_back(cyc);
            step();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (drawing_board !== 1'b1 || row_addr !== 5'd19 || level !== 4'd0 || lines_total !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: board=%0b row=%0d lvl=%0d lines=%0d expected 1/19/0/0",
                     drawing_board, row_addr, level, lines_total);
        end
        checks++;
        if ({gen_shape, new_lines, set_shape, fall_step, lock_piece, clear_row, paused, game_over} !== 8'd0) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 00000000",
                     {gen_shape, new_lines, set_shape, fall_step, lock_piece, clear_row, paused, game_over});
        end
        step();
    endtask

    task automatic test_start_seq();
        logic [3:0] e;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_vec_q.push_back(4'b1000);
        exp_vec_q.push_back(4'b0100);
        exp_vec_q.push_back(4'b0100);
        exp_vec_q.push_back(4'b0010);
        for (int i = 1; i <= 4; i++) begin
            #1;
            e = exp_vec_q.pop_front();
            checks++;
            if ({gen_shape, new_lines, set_shape, drawing_board} !== e) begin
                errors++;
                $display("FAIL start_cycle%0d: got %b expected %b", i,
                         {gen_shape, new_lines, set_shape, drawing_board}, e);
            end
            step();
        end
        key_rot = 1'b1;
        #1;
        checks++;
        if (rotate !== 1'b1) begin
            errors++;
            $display("FAIL fall_at_cycle5: rotate=%0b expected 1", rotate);
        end
        step();
        key_rot = 1'b0;
    endtask

    task automatic test_gravity();
        int c0, p, g;
        p = period_of(0);
        frame_tick = 1'b1;
        c0 = cyc;
        for (int k = 1; k * p <= 150; k++) exp_q.push_back(c0 + k * p - 1);
        observe_falls(150);
        checks++;
        if (seen_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL gravity_count: got %0d steps expected %0d", seen_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && seen_q.size() > 0) begin
            g = seen_q.pop_front();
            checks++;
            if (g != exp_q[0]) begin
                errors++;
                $display("FAIL gravity_cycle: got %0d expected %0d", g, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        key_drop = 1'b1;
        c0 = cyc;
        observe_falls(5);
        checks++;
        if (seen_q.size() != 5 || seen_q[0] != c0 || seen_q[4] != c0 + 4) begin
            errors++;
            $display("FAIL soft_drop: got %0d steps expected 5 from cycle %0d", seen_q.size(), c0);
        end
        key_rot = 1'b1;
        #1;
        checks++;
        if (fall_step !== 1'b1 || rotate !== 1'b0) begin
            errors++;
            $display("FAIL key_masked_on_step: fall=%0b rot=%0b expected 1/0", fall_step, rotate);
        end
        step();
        key_rot = 1'b0; key_drop = 1'b0; frame_tick = 1'b0;
        key_left = 1'b1; key_right = 1'b1;
        #1;
        checks++;
        if ({move_left, move_right} !== 2'b00) begin
            errors++;
            $display("FAIL left_right_both: got %b expected 00", {move_left, move_right});
        end
        step();
        key_right = 1'b0;
        #1;
        checks++;
        if ({move_left, move_right} !== 2'b10) begin
            errors++;
            $display("FAIL left_only: got %b expected 10", {move_left, move_right});
        end
        step();
        key_left = 1'b0;
    endtask

    task automatic test_lock_clear();
        bit to;
        int gs, lock_cyc;
        board = '0;
        board[19] = 1'b1;
        board[17] = 1'b1;
        key_drop = 1'b1; landed = 1'b1; frame_tick = 1'b1;
        #1;
        checks++;
        if (fall_step !== 1'b0) begin
            errors++;
            $display("FAIL landed_no_step: fall_step=%0b expected 0", fall_step);
        end
        step();
        key_drop = 1'b0; landed = 1'b0; frame_tick = 1'b0;
        #1;
        lock_cyc = cyc;
        checks++;
        if (lock_piece !== 1'b1) begin
            errors++;
            $display("FAIL lock_piece: got %0b expected 1", lock_piece);
        end
        step();
        exp_q.push_back(19);
        exp_q.push_back(17);
        collect_clears(to, gs);
        lines_model += 2;
        checks++;
        if (to || seen_q.size() != 2) begin
            errors++;
            $display("FAIL clear_rows: timeout=%0b clears=%0d expected 2", to, seen_q.size());
        end
        while (exp_q.size() > 0 && seen_q.size() > 0) begin
            checks++;
            if (seen_q[0] != exp_q[0]) begin
                errors++;
                $display("FAIL clear_addr: got %0d expected %0d", seen_q[0], exp_q[0]);
            end
            void'(seen_q.pop_front());
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        checks++;
        if (gs != lock_cyc + 23) begin
            errors++;
            $display("FAIL clear_duration: gen_shape at %0d expected %0d", gs, lock_cyc + 23);
        end
        checks++;
        if (lines_total !== 16'(lines_model)) begin
            errors++;
            $display("FAIL lines_after_lock: got %0d expected %0d", lines_total, lines_model);
        end
        wait_set_shape(to);
    endtask

    task automatic check_period(input string tag);
        int c0, p;
        p = period_of(level_of(lines_model));
        frame_tick = 1'b1;
        c0 = cyc;
        exp_q.push_back(c0 + p - 1);
        exp_q.push_back(c0 + 2 * p - 1);
        observe_falls(2 * p);
        frame_tick = 1'b0;
        checks++;
        if (seen_q.size() != 2 || seen_q[0] != exp_q[0] || seen_q[1] != exp_q[1]) begin
            errors++;
            $display("FAIL %s: got %0d steps first at %0d expected cycles %0d,%0d", tag,
                     seen_q.size(), (seen_q.size() > 0) ? seen_q[0] : -1, exp_q[0], exp_q[1]);
        end
        exp_q.delete();
    endtask

    task automatic test_levels();
        bit to, to2;
        int n;
        board = '0;
        for (int r = 12; r < 20; r++) board[r] = 1'b1;
        do_lock(to, n);
        lines_model += n;
        checks++;
        if (to || n != 8 || level !== 4'd1 || lines_total !== 16'd10) begin
            errors++;
            $display("FAIL level_up: clears=%0d lvl=%0d lines=%0d expected 8/1/10", n, level, lines_total);
        end
        wait_set_shape(to);
        check_period("period_level1");
        force_full = 1'b1;
        for (int k = 0; k < 8; k++) begin
            do_lock(to, n);
            lines_model += n;
            wait_set_shape(to2);
            checks++;
            if (to || to2 || n != 20) begin
                errors++;
                $display("FAIL clear_cap: clears=%0d timeout=%0b expected 20", n, to | to2);
            end
            if (k == 4) begin
                checks++;
                if (level !== 4'(level_of(lines_model))) begin
                    errors++;
                    $display("FAIL level_11: got %0d expected %0d", level, level_of(lines_model));
                end
                force_full = 1'b0;
                check_period("period_floor");
                force_full = 1'b1;
            end
        end
        force_full = 1'b0;
        checks++;
        if (level !== 4'd15 || lines_total !== 16'(lines_model)) begin
            errors++;
            $display("FAIL level_saturate: lvl=%0d lines=%0d expected 15/%0d", level, lines_total, lines_model);
        end
    endtask

    task automatic test_pause();
        int c;
        frame_tick = 1'b1;
        observe_falls(2);
        frame_tick = 1'b0;
        pause = 1'b1;
        step();
        pause = 1'b0;
        frame_tick = 1'b1; key_rot = 1'b1; key_left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (paused !== 1'b1 || {fall_step, rotate, move_left, move_right} !== 4'd0) begin
                errors++;
                $display("FAIL paused_quiet: paused=%0b pulses=%b expected 1/0000", paused,
                         {fall_step, rotate, move_left, move_right});
            end
            step();
        end
        frame_tick = 1'b0; key_rot = 1'b0; key_left = 1'b0;
        pause = 1'b1;
        step();
        pause = 1'b0;
        frame_tick = 1'b1;
        c = cyc;
        exp_q.push_back(c + 1);
        observe_falls(2);
        checks++;
        if (seen_q.size() != 1 || seen_q[0] != exp_q[0]) begin
            errors++;
            $display("FAIL pause_resume: got %0d steps expected one at %0d", seen_q.size(), exp_q[0]);
        end
        exp_q.delete();
        observe_falls(3);
        pause = 1'b1;
        #1;
        checks++;
        if (fall_step !== 1'b0) begin
            errors++;
            $display("FAIL pause_beats_step: fall_step=%0b expected 0", fall_step);
        end
        step();
        pause = 1'b0; frame_tick = 1'b0;
        #1;
        checks++;
        if (paused !== 1'b1) begin
            errors++;
            $display("FAIL pause_on_due: paused=%0b expected 1", paused);
        end
        pause = 1'b1;
        step();
        pause = 1'b0; frame_tick = 1'b1;
        #1;
        checks++;
        if (fall_step !== 1'b1) begin
            errors++;
            $display("FAIL deferred_step: fall_step=%0b expected 1", fall_step);
        end
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_game_over();
        bit to, to2;
        int n;
        board = '0;
        do_lock(to, n);
        spawn_blocked = 1'b1;
        wait_set_shape(to2);
        spawn_blocked = 1'b0;
        #1;
        checks++;
        if (to || to2 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL game_over: got %0b timeout=%0b expected 1", game_over, to | to2);
        end
        key_rot = 1'b1; pause = 1'b1; frame_tick = 1'b1;
        step();
        #1;
        checks++;
        if (game_over !== 1'b1 || {fall_step, rotate, paused} !== 3'd0) begin
            errors++;
            $display("FAIL lost_ignores: over=%0b pulses=%b expected 1/000", game_over,
                     {fall_step, rotate, paused});
        end
        key_rot = 1'b0; pause = 1'b0; frame_tick = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        checks++;
        if (drawing_board !== 1'b1 || lines_total !== 16'(lines_model)) begin
            errors++;
            $display("FAIL back_to_idle: board=%0b lines=%0d expected 1/%0d", drawing_board,
                     lines_total, lines_model);
        end
        pause = 1'b1;
        step();
        pause = 1'b0;
        #1;
        checks++;
        if (paused !== 1'b0 || drawing_board !== 1'b1) begin
            errors++;
            $display("FAIL pause_in_idle: paused=%0b board=%0b expected 0/1", paused, drawing_board);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        lines_model = 0;
        #1;
        checks++;
        if (lines_total !== 16'd0 || level !== 4'd0 || gen_shape !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears: lines=%0d lvl=%0d gen=%0b expected 0/0/1", lines_total,
                     level, gen_shape);
        end
        step();
    endtask

    task automatic test_reset_in_clear();
        bit to;
        wait_set_shape(to);
        board = '0;
        board[16] = 1'b1;
        key_drop = 1'b1; landed = 1'b1; frame_tick = 1'b1;
        step();
        key_drop = 1'b0; landed = 1'b0; frame_tick = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        checks++;
        if (to || row_addr !== 5'd16 || clear_row !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_quiet: row=%0d clear=%0b expected 16/0", row_addr, clear_row);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (drawing_board !== 1'b1 || row_addr !== 5'd19) begin
            errors++;
            $display("FAIL reset_abort: board=%0b row=%0d expected 1/19", drawing_board, row_addr);
        end
    endtask

    initial begin
        test_reset();
        test_start_seq();
        test_gravity();
        test_lock_clear();
        test_levels();
        test_pause();
        test_game_over();
        test_reset_in_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
